weight_buffer: RTL and testbench

- Holds one convolution kernel of DEPTH weights for the PE array.
- The upstream weight driver streams words into it over a valid/ready handshake.
- On a flush request, the whole kernel is streamed out in address order to the PE array under downstream backpressure.
- Read-out is non-destructive, so one load can serve any number of flushes.

---
 rtl/weight_buff_pkg.sv | 18 +
 rtl/weight_buffer_if.sv | 34 +++
 rtl/weight_buff_bank.sv | 35 +++
 rtl/weight_buffer.sv | 194 +++++++++++++++++++
 tb/tb_weight_buffer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_buff_pkg.sv
// Shared types and default sizing for the weight buffer, the PE array and the weight driver bench.
package weight_buff_pkg;

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_LOAD,
        WB_FULL,
        WB_FLUSH
    } wb_state_t;

    localparam int WB_DATA_WIDTH = 16;
    localparam int WB_DEPTH      = 9;

    function automatic int wb_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/weight_buffer_if.sv
// Weight buffer bus: write side from the weight driver, flush side to the PE array, plus FSM debug taps.
// Both streams use valid/ready: a word moves on a rising edge where valid && ready; valid never waits on ready.
interface weight_buffer_if
    import weight_buff_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic                  clear;
    logic                  flush;
    logic [DATA_WIDTH-1:0] weight_out;
    logic                  flush_valid;
    logic                  weight_ready;
    logic                  flush_done;
    logic                  full;
    logic                  empty;
    wb_state_t             dbg_state;
    logic [7:0]            dbg_wr_ptr;
    logic [7:0]            dbg_rd_ptr;

    modport slave (
        input  data_in, data_in_valid, clear, flush, weight_ready,
        output data_in_ready, weight_out, flush_valid, flush_done, full, empty,
        output dbg_state, dbg_wr_ptr, dbg_rd_ptr
    );

    modport master (
        output data_in, data_in_valid, clear, flush, weight_ready,
        input  data_in_ready, weight_out, flush_valid, flush_done, full, empty,
        input  dbg_state, dbg_wr_ptr, dbg_rd_ptr
    );
endinterface

// File: rtl/weight_buff_bank.sv
// DEPTH x DATA_WIDTH kernel store: synchronous write, registered read that holds while i_rd_en is low.
module weight_buff_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 9,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the output word, so it must stay put during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/weight_buffer.sv
// Single-kernel weight buffer: load over valid/ready, non-destructive flush to the PE array.
// Define WEIGHT_BUFF_PINGPONG_EN for two banks (flush from active bank while loading the shadow bank).
module weight_buffer
    import weight_buff_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int DEPTH      = WB_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    weight_buffer_if.slave bus
);
    localparam int                ADDR_W    = wb_addr_w(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    wb_state_t             r_state;
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic                  r_flush_valid;
    logic                  r_flush_done;

    logic                  w_data_in_ready;
    logic                  w_wr_fire;
    logic                  w_wr_last;
    logic [ADDR_W-1:0]     w_wr_ptr_next;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_flush_start;
    logic                  w_rd_en;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_wr_fire     = bus.data_in_valid && w_data_in_ready && !bus.clear;
    assign w_wr_last     = w_wr_fire && (r_wr_ptr == LAST_ADDR);
    assign w_wr_ptr_next = (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
    assign w_beat        = r_flush_valid && bus.weight_ready && !bus.clear;
    assign w_last_beat   = w_beat && (r_rd_ptr == LAST_ADDR);

`ifdef WEIGHT_BUFF_PINGPONG_EN
    logic                  r_active;
    logic                  r_shadow_full;
    logic                  w_swap;
    logic [DATA_WIDTH-1:0] w_rd_data0;
    logic [DATA_WIDTH-1:0] w_rd_data1;

    assign w_data_in_ready = !r_shadow_full;
    // Swap only when the active bank is idle or is handing over its last beat this edge.
    assign w_swap          = !bus.clear && (r_shadow_full || w_wr_last) &&
                             ((r_state != WB_FLUSH) || w_last_beat);
    assign w_flush_start   = (r_state == WB_FULL) && bus.flush && !bus.clear && !w_swap;
`else
    assign w_data_in_ready = (r_state == WB_IDLE) || (r_state == WB_LOAD);
    assign w_flush_start   = (r_state == WB_FULL) && bus.flush && !bus.clear;
`endif

    // Prefetch: the read register always holds the word at r_rd_ptr while a flush is running.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_rd_ptr;
        if (w_flush_start) begin
            w_rd_en   = 1'b1;
            w_rd_addr = '0;
        end else if (w_beat && !w_last_beat) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= WB_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_flush_valid <= 1'b0;
            r_flush_done  <= 1'b0;
`ifdef WEIGHT_BUFF_PINGPONG_EN
            r_active      <= 1'b0;
            r_shadow_full <= 1'b0;
`endif
        end else if (bus.clear) begin
            r_state       <= WB_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_flush_valid <= 1'b0;
            r_flush_done  <= 1'b0;
`ifdef WEIGHT_BUFF_PINGPONG_EN
            r_shadow_full <= 1'b0;
`endif
        end else begin
            r_flush_done <= 1'b0;
            if (w_wr_fire) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            case (r_state)
                WB_IDLE, WB_LOAD: begin
                    if (w_wr_last) begin
                        r_state <= WB_FULL;
                    end else if (w_wr_fire) begin
                        r_state <= WB_LOAD;
                    end
                end
                WB_FULL: begin
                    if (w_flush_start) begin
                        r_state       <= WB_FLUSH;
                        r_flush_valid <= 1'b1;
                        r_rd_ptr      <= '0;
                    end
                end
                WB_FLUSH: begin
                    if (w_last_beat) begin
                        r_state       <= WB_FULL;
                        r_flush_valid <= 1'b0;
                        r_rd_ptr      <= '0;
                        r_flush_done  <= 1'b1;
                    end else if (w_beat) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                default: r_state <= WB_IDLE;
            endcase
`ifdef WEIGHT_BUFF_PINGPONG_EN
            if (w_swap) begin
                r_active      <= !r_active;
                r_shadow_full <= 1'b0;
                r_state       <= WB_FULL;
                r_rd_ptr      <= '0;
                r_flush_valid <= 1'b0;
            end else if (w_wr_last) begin
                r_shadow_full <= 1'b1;
            end
`endif
        end
    end

`ifdef WEIGHT_BUFF_PINGPONG_EN
    // Bank i is written while it is the shadow (r_active != i) and read while active.
    weight_buff_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_wr_fire && r_active),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(bus.data_in),
        .i_rd_en  (w_rd_en && !r_active),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data0)
    );

    weight_buff_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_wr_fire && !r_active),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(bus.data_in),
        .i_rd_en  (w_rd_en && r_active),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data1)
    );

    assign w_rd_data = r_active ? w_rd_data1 : w_rd_data0;
`else
    weight_buff_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (w_wr_fire),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(bus.data_in),
        .i_rd_en  (w_rd_en),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data)
    );
`endif

    assign bus.data_in_ready = w_data_in_ready;
    assign bus.weight_out    = w_rd_data;
    assign bus.flush_valid   = r_flush_valid;
    assign bus.flush_done    = r_flush_done;
    assign bus.full          = (r_state == WB_FULL) || (r_state == WB_FLUSH);
    assign bus.empty         = (r_state == WB_IDLE);
    assign bus.dbg_state     = r_state;
    assign bus.dbg_wr_ptr    = 8'(r_wr_ptr);
    assign bus.dbg_rd_ptr    = 8'(r_rd_ptr);
endmodule

// File: tb/tb_weight_buffer.sv
// Directed bench for weight_buffer: table-driven load checks plus flush, backpressure, clear and reset sequences.
module tb_weight_buffer;
    import weight_buff_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 9;

    typedef struct {
        logic [DW-1:0] din;
        logic [7:0]    exp_wr_ptr;
        logic          exp_ready;
        logic          exp_full;
        logic          exp_empty;
        wb_state_t     exp_state;
    } load_vec_t;

    logic          clk = 1'b0;
    logic          rst;
    int            checks;
    int            failures;
    logic [DW-1:0] exp_q[$];
    load_vec_t     vecs[10];

    always #5 clk = ~clk;

    weight_buffer_if #(.DATA_WIDTH(DW)) bus ();

    weight_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_words(input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            bus.data_in       = base + DW'(k);
            bus.data_in_valid = 1'b1;
            tick();
        end
        bus.data_in_valid = 1'b0;
    endtask

    task automatic push_kernel(input logic [DW-1:0] base);
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(base + DW'(k));
        end
    endtask

    task automatic start_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_latency_valid", 32'(bus.flush_valid), 1);
    endtask

    // mode 0: weight_ready always high; mode 1: ready pattern 1,0,0 repeating.
    task automatic collect(input int mode, input int budget);
        int            cyc;
        logic          stalled;
        logic [DW-1:0] held;
        logic [DW-1:0] e;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (stalled) begin
                chk("stall_hold_valid", 32'(bus.flush_valid), 1);
                chk("stall_hold_data", 32'(bus.weight_out), 32'(held));
            end
            chk("no_early_done", 32'(bus.flush_done), 0);
            bus.weight_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (bus.flush_valid && bus.weight_ready) begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(bus.weight_out), 32'(e));
                stalled = 1'b0;
            end else if (bus.flush_valid) begin
                stalled = 1'b1;
                held    = bus.weight_out;
            end else begin
                stalled = 1'b0;
            end
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            chk("flush_timeout_beats_left", 32'(exp_q.size()), 0);
            exp_q.delete();
        end else begin
            chk("done_after_last", 32'(bus.flush_done), 1);
            chk("valid_after_last", 32'(bus.flush_valid), 0);
            chk("full_after_flush", 32'(bus.full), 1);
        end
        bus.weight_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int            dones;
        int            beats;
        logic [DW-1:0] e;

        checks            = 0;
        failures          = 0;
        rst               = 1'b1;
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        bus.clear         = 1'b0;
        bus.flush         = 1'b0;
        bus.weight_ready  = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_weight_out", 32'(bus.weight_out), 0);
        chk("rst_flush_valid", 32'(bus.flush_valid), 0);
        chk("rst_flush_done", 32'(bus.flush_done), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_ready", 32'(bus.data_in_ready), 1);
        chk("rst_state", 32'(bus.dbg_state), 32'(WB_IDLE));
        chk("rst_wr_ptr", 32'(bus.dbg_wr_ptr), 0);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("idle_flush_ignored_valid", 32'(bus.flush_valid), 0);
        chk("idle_flush_ignored_state", 32'(bus.dbg_state), 32'(WB_IDLE));

        vecs[0] = '{16'h0001, 8'd1, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[1] = '{16'h0002, 8'd2, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[2] = '{16'h0003, 8'd3, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[3] = '{16'h0004, 8'd4, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[4] = '{16'h0005, 8'd5, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[5] = '{16'h0006, 8'd6, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[6] = '{16'h0007, 8'd7, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[7] = '{16'h0008, 8'd8, 1'b1, 1'b0, 1'b0, WB_LOAD};
        vecs[8] = '{16'h0009, 8'd0, 1'b0, 1'b1, 1'b0, WB_FULL};
        vecs[9] = '{16'h000A, 8'd0, 1'b0, 1'b1, 1'b0, WB_FULL};

        for (int i = 0; i < 10; i++) begin
            bus.data_in       = vecs[i].din;
            bus.data_in_valid = 1'b1;
            tick();
            chk("load_wr_ptr", 32'(bus.dbg_wr_ptr), 32'(vecs[i].exp_wr_ptr));
            chk("load_ready", 32'(bus.data_in_ready), 32'(vecs[i].exp_ready));
            chk("load_full", 32'(bus.full), 32'(vecs[i].exp_full));
            chk("load_empty", 32'(bus.empty), 32'(vecs[i].exp_empty));
            chk("load_state", 32'(bus.dbg_state), 32'(vecs[i].exp_state));
        end
        bus.data_in_valid = 1'b0;

        push_kernel(16'h0001);
        start_flush();
        chk("flush_first_word", 32'(bus.weight_out), 1);
        collect(0, 40);
        tick();
        chk("done_one_cycle", 32'(bus.flush_done), 0);
        chk("full_stays", 32'(bus.full), 1);

        push_kernel(16'h0001);
        start_flush();
        collect(1, 60);
        tick();

        exp_q.delete();
        push_kernel(16'h0001);
        push_kernel(16'h0001);
        push_kernel(16'h0001);
        dones            = 0;
        beats            = 0;
        bus.weight_ready = 1'b1;
        bus.flush        = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            if (bus.flush_valid) begin
                beats++;
                if (exp_q.size() == 0) begin
                    chk("b2b_extra_beat", 32'(bus.weight_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("b2b_beat_data", 32'(bus.weight_out), 32'(e));
                end
            end
            if (bus.flush_done) begin
                dones++;
                chk("b2b_gap_valid", 32'(bus.flush_valid), 0);
            end
            if (i == 29) bus.flush = 1'b0;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk("b2b_quiet_valid", 32'(bus.flush_valid), 0);
            tick();
        end
        chk("b2b_dones", 32'(dones), 3);
        chk("b2b_beats", 32'(beats), 27);
        exp_q.delete();

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clear_pre_beat", 32'(bus.weight_out), 32'(i + 1));
            tick();
        end
        chk("clear_beat4_valid", 32'(bus.flush_valid), 1);
        chk("clear_beat4_data", 32'(bus.weight_out), 4);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clear_valid", 32'(bus.flush_valid), 0);
        chk("clear_no_done", 32'(bus.flush_done), 0);
        chk("clear_empty", 32'(bus.empty), 1);
        chk("clear_full", 32'(bus.full), 0);
        chk("clear_ready", 32'(bus.data_in_ready), 1);
        chk("clear_wr_ptr", 32'(bus.dbg_wr_ptr), 0);
        tick();
        chk("clear_no_late_done", 32'(bus.flush_done), 0);
        load_words(16'h00A0, 9);
        chk("reload_full", 32'(bus.full), 1);
        push_kernel(16'h00A0);
        start_flush();
        collect(0, 40);
        tick();

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        load_words(16'h00B0, 5);
        chk("midload_wr_ptr", 32'(bus.dbg_wr_ptr), 5);
        bus.data_in       = 16'h00B5;
        bus.data_in_valid = 1'b1;
        rst               = 1'b1;
        tick();
        rst               = 1'b0;
        bus.data_in_valid = 1'b0;
        chk("rst_mid_empty", 32'(bus.empty), 1);
        chk("rst_mid_wr_ptr", 32'(bus.dbg_wr_ptr), 0);
        chk("rst_mid_ready", 32'(bus.data_in_ready), 1);
        chk("rst_mid_weight_out", 32'(bus.weight_out), 0);
        load_words(16'h00C0, 9);
        chk("rst_reload_full", 32'(bus.full), 1);
        chk("rst_reload_ready", 32'(bus.data_in_ready), 0);
        push_kernel(16'h00C0);
        start_flush();
        collect(0, 40);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
